// File: rtl/mdu_pkg.sv
// Shared encodings and default latencies for the MIPS multiply/divide unit controller.
package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam int unsigned DEF_MULT_LAT = 5;
  localparam int unsigned DEF_DIV_LAT  = 10;
  localparam int unsigned DEF_CNT_W    = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu_latency_counter.sv
// Loadable down-counter that flags the final cycle of an MDU operation.
module mdu_latency_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  input  logic             clear_i,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mdu_controller.sv
// MDU sequencing controller: issue, fixed-latency count, HI/LO commit, mthi/mtlo and MD stall.
// Optional cancel port `flush` is built in when MDU_FLUSH_EN is defined.
module mdu_controller
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_LAT = DEF_MULT_LAT,
  parameter int unsigned DIV_LAT  = DEF_DIV_LAT,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_B,
  input  logic [31:0] res_hi,
  input  logic [31:0] res_lo,
  input  logic        mt_hi,
  input  logic        mt_lo,
  input  logic [31:0] mt_data,
  input  logic        md_in_d,
`ifdef MDU_FLUSH_EN
  input  logic        flush,
`endif
  output logic        load,
  output logic [1:0]  op_q,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_e       state_q, state_d;
  logic [1:0]       op_d;
  logic             dz_q, dz_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic             flush_w;
  logic             is_idle, accept, last, commit;
  logic [CNT_W-1:0] lat_sel;

`ifdef MDU_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign is_idle = (state_q == ST_IDLE);
  assign accept  = start & is_idle & ~flush_w & ~reset;
  assign lat_sel = op[1] ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
  // Divide-by-zero still spends the full latency but never writes HI/LO.
  assign commit  = ~is_idle & last & ~dz_q & ~flush_w;

  mdu_latency_counter #(
    .CNT_W(CNT_W)
  ) u_lat_cnt (
    .clk       (clk),
    .reset     (reset),
    .load_i    (accept),
    .load_val_i(lat_sel),
    .dec_i     (~is_idle),
    .clear_i   (~is_idle & flush_w),
    .last_o    (last)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!flush_w) begin
          if (mt_hi) hi_d = mt_data;
          if (mt_lo) lo_d = mt_data;
        end
        if (accept) begin
          state_d = ST_BUSY;
          op_d    = op;
          dz_d    = op[1] & (src_B == 32'd0);
        end
      end
      ST_BUSY: begin
        if (flush_w || last) state_d = ST_IDLE;
        if (commit) begin
          hi_d = res_hi;
          lo_d = res_lo;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MULT;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy     = ~is_idle;
  assign load     = accept;
  // Stall covers the issue cycle so a dependent MD op in D never sees stale HI/LO.
  assign md_stall = md_in_d & (busy | start) & ~reset;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mdu_controller.sv
// Directed self-checking bench for mdu_controller; flush scenarios build with MDU_FLUSH_EN.
module tb_mdu_controller;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_B, res_hi, res_lo, mt_data;
  logic        mt_hi, mt_lo, md_in_d;
`ifdef MDU_FLUSH_EN
  logic        flush;
`endif
  logic        load, busy, md_stall;
  logic [1:0]  op_q;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_hi, exp_lo;

  always #5 clk = ~clk;

  mdu_controller dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .src_B   (src_B),
    .res_hi  (res_hi),
    .res_lo  (res_lo),
    .mt_hi   (mt_hi),
    .mt_lo   (mt_lo),
    .mt_data (mt_data),
    .md_in_d (md_in_d),
`ifdef MDU_FLUSH_EN
    .flush   (flush),
`endif
    .load    (load),
    .op_q    (op_q),
    .busy    (busy),
    .md_stall(md_stall),
    .hi      (hi),
    .lo      (lo)
  );

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic to_sample();
    @(negedge clk);
  endtask

  task automatic test_reset();
    to_drive();
    reset = 1'b1; start = 1'b0; op = 2'b00; src_B = '0; res_hi = '0; res_lo = '0;
    mt_hi = 1'b0; mt_lo = 1'b0; mt_data = '0; md_in_d = 1'b0;
`ifdef MDU_FLUSH_EN
    flush = 1'b0;
`endif
    to_drive();
    to_drive();
    reset = 1'b0;
    to_sample();
    n_checks++;
    if (busy !== 1'b0 || load !== 1'b0 || md_stall !== 1'b0 || op_q !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy=%b load=%b md_stall=%b op_q=%b, required all 0",
               busy, load, md_stall, op_q);
    end
    n_checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_hilo: hi=%h lo=%h, required 0/0", hi, lo);
    end
    exp_hi = 32'h0;
    exp_lo = 32'h0;
  endtask

  task automatic test_mt();
    to_drive();
    mt_hi = 1'b1; mt_data = 32'h1234_5678;
    to_sample();
    n_checks++;
    if (hi !== 32'h0) begin
      n_fail++;
      $display("FAIL mt_before_edge: hi=%h, required 00000000", hi);
    end
    to_drive();
    mt_hi = 1'b0; mt_data = '0;
    to_sample();
    exp_hi = 32'h1234_5678;
    n_checks++;
    if (hi !== exp_hi || lo !== 32'h0) begin
      n_fail++;
      $display("FAIL mt_hi_write: hi=%h lo=%h, required %h/00000000", hi, lo, exp_hi);
    end
  endtask

  task automatic test_mult();
    to_drive();
    start = 1'b1; op = 2'b00; src_B = 32'd3; res_hi = 32'h1; res_lo = 32'h2;
    to_sample();
    n_checks++;
    if (load !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mult_issue: load=%b busy=%b, required load=1 busy=0", load, busy);
    end
    to_drive();
    start = 1'b0;
    for (int i = 1; i <= MULT_LAT + 1; i++) begin
      to_sample();
      n_checks++;
      if (i <= MULT_LAT) begin
        if (busy !== 1'b1 || load !== 1'b0 || hi !== exp_hi || op_q !== 2'b00) begin
          n_fail++;
          $display("FAIL mult_busy_c%0d: busy=%b load=%b hi=%h op_q=%b, required 1/0/%h/00",
                   i, busy, load, hi, op_q, exp_hi);
        end
      end else if (busy !== 1'b0 || hi !== 32'h1 || lo !== 32'h2) begin
        n_fail++;
        $display("FAIL mult_commit: busy=%b hi=%h lo=%h, required 0/00000001/00000002",
                 busy, hi, lo);
      end
    end
    exp_hi = 32'h1;
    exp_lo = 32'h2;
  endtask

  task automatic test_div_zero();
    to_drive();
    mt_hi = 1'b1; mt_data = 32'hAA;
    to_drive();
    mt_hi = 1'b0; mt_lo = 1'b1; mt_data = 32'hBB;
    to_drive();
    mt_lo = 1'b0; mt_data = '0;
    start = 1'b1; op = 2'b11; src_B = 32'h0; res_hi = 32'hDEAD; res_lo = 32'hBEEF;
    exp_hi = 32'hAA;
    exp_lo = 32'hBB;
    to_sample();
    n_checks++;
    if (load !== 1'b1 || hi !== exp_hi || lo !== exp_lo) begin
      n_fail++;
      $display("FAIL divz_issue: load=%b hi=%h lo=%h, required 1/000000aa/000000bb",
               load, hi, lo);
    end
    to_drive();
    start = 1'b0;
    for (int i = 1; i <= DIV_LAT + 1; i++) begin
      to_sample();
      n_checks++;
      if (busy !== (i <= DIV_LAT) || hi !== exp_hi || lo !== exp_lo) begin
        n_fail++;
        $display("FAIL divz_c%0d: busy=%b hi=%h lo=%h, required %b/%h/%h",
                 i, busy, hi, lo, (i <= DIV_LAT), exp_hi, exp_lo);
      end
    end
    n_checks++;
    if (op_q !== 2'b11) begin
      n_fail++;
      $display("FAIL divz_opq: op_q=%b, required 11", op_q);
    end
  endtask

  task automatic test_stall();
    to_drive();
    md_in_d = 1'b1;
    start = 1'b1; op = 2'b10; src_B = 32'd7; res_hi = 32'h33; res_lo = 32'h44;
    to_sample();
    n_checks++;
    if (md_stall !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_issue: md_stall=%b busy=%b, required 1/0", md_stall, busy);
    end
    to_drive();
    start = 1'b0;
    for (int i = 1; i <= DIV_LAT + 1; i++) begin
      to_sample();
      n_checks++;
      if (md_stall !== (i <= DIV_LAT) || busy !== (i <= DIV_LAT)) begin
        n_fail++;
        $display("FAIL stall_c%0d: md_stall=%b busy=%b, required %b/%b",
                 i, md_stall, busy, (i <= DIV_LAT), (i <= DIV_LAT));
      end
    end
    exp_hi = 32'h33;
    exp_lo = 32'h44;
    n_checks++;
    if (hi !== exp_hi || lo !== exp_lo) begin
      n_fail++;
      $display("FAIL stall_commit: hi=%h lo=%h, required %h/%h", hi, lo, exp_hi, exp_lo);
    end
    to_drive();
    md_in_d = 1'b0;
  endtask

  task automatic test_ignore_busy();
    to_drive();
    start = 1'b1; op = 2'b01; src_B = 32'd9; res_hi = 32'h55; res_lo = 32'h66;
    to_drive();
    start = 1'b0;
    for (int i = 1; i <= MULT_LAT + 1; i++) begin
      to_sample();
      if (i == 3) begin
        n_checks++;
        if (load !== 1'b0) begin
          n_fail++;
          $display("FAIL ign_load: load=%b, required 0", load);
        end
      end
      n_checks++;
      if (busy !== (i <= MULT_LAT)) begin
        n_fail++;
        $display("FAIL ign_busy_c%0d: busy=%b, required %b", i, busy, (i <= MULT_LAT));
      end
      if (i == 2) begin
        to_drive();
        start = 1'b1; op = 2'b10; mt_lo = 1'b1; mt_hi = 1'b1; mt_data = 32'h99;
      end else if (i == 3) begin
        to_drive();
        start = 1'b0; op = 2'b00; mt_lo = 1'b0; mt_hi = 1'b0; mt_data = '0;
      end
    end
    exp_hi = 32'h55;
    exp_lo = 32'h66;
    n_checks++;
    if (hi !== exp_hi || lo !== exp_lo || op_q !== 2'b01) begin
      n_fail++;
      $display("FAIL ign_commit: hi=%h lo=%h op_q=%b, required %h/%h/01",
               hi, lo, op_q, exp_hi, exp_lo);
    end
  endtask

  task automatic test_mt_with_start();
    to_drive();
    start = 1'b1; op = 2'b00; src_B = 32'd2; res_hi = 32'h77; res_lo = 32'h88;
    mt_hi = 1'b1; mt_data = 32'hCAFE;
    to_drive();
    start = 1'b0; mt_hi = 1'b0; mt_data = '0;
    for (int i = 1; i <= MULT_LAT + 1; i++) begin
      to_sample();
      n_checks++;
      if (i <= MULT_LAT) begin
        if (hi !== 32'hCAFE || lo !== exp_lo) begin
          n_fail++;
          $display("FAIL mtstart_c%0d: hi=%h lo=%h, required 0000cafe/%h", i, hi, lo, exp_lo);
        end
      end else if (hi !== 32'h77 || lo !== 32'h88 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL mtstart_commit: hi=%h lo=%h busy=%b, required 00000077/00000088/0",
                 hi, lo, busy);
      end
    end
    exp_hi = 32'h77;
    exp_lo = 32'h88;
  endtask

`ifdef MDU_FLUSH_EN
  task automatic test_flush();
    to_drive();
    start = 1'b1; op = 2'b10; src_B = 32'd5; res_hi = 32'h1111; res_lo = 32'h2222;
    to_drive();
    start = 1'b0;
    to_drive();
    to_drive();
    flush = 1'b1;
    to_sample();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_busy3: busy=%b, required 1", busy);
    end
    to_drive();
    flush = 1'b0;
    start = 1'b1; op = 2'b00; res_hi = 32'h3; res_lo = 32'h4;
    to_sample();
    n_checks++;
    if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo || load !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_cancel: busy=%b hi=%h lo=%h load=%b, required 0/%h/%h/1",
               busy, hi, lo, load, exp_hi, exp_lo);
    end
    to_drive();
    start = 1'b0;
    for (int i = 1; i <= MULT_LAT + 1; i++) begin
      to_sample();
      n_checks++;
      if (busy !== (i <= MULT_LAT)) begin
        n_fail++;
        $display("FAIL flush_restart_c%0d: busy=%b, required %b", i, busy, (i <= MULT_LAT));
      end
    end
    exp_hi = 32'h3;
    exp_lo = 32'h4;
    n_checks++;
    if (hi !== exp_hi || lo !== exp_lo) begin
      n_fail++;
      $display("FAIL flush_restart_commit: hi=%h lo=%h, required %h/%h", hi, lo, exp_hi, exp_lo);
    end
    to_drive();
    flush = 1'b1; start = 1'b1; mt_hi = 1'b1; mt_data = 32'hF00D;
    to_sample();
    n_checks++;
    if (load !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_start_load: load=%b, required 0", load);
    end
    to_drive();
    flush = 1'b0; start = 1'b0; mt_hi = 1'b0; mt_data = '0;
    to_sample();
    n_checks++;
    if (busy !== 1'b0 || hi !== exp_hi) begin
      n_fail++;
      $display("FAIL flush_start_suppr: busy=%b hi=%h, required 0/%h", busy, hi, exp_hi);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mt();
    test_mult();
    test_div_zero();
    test_stall();
    test_ignore_busy();
    test_mt_with_start();
`ifdef MDU_FLUSH_EN
    test_flush();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
